snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Sequencing controller for the snake game datapath. It owns the game-state machine (idle / run / pause / over), generates the movement step strobe with a length-dependent speed, and buffers debounced left/right button pulses in a 2-deep turn queue so fast presses are not lost. Each step issues at most one turn to the snake plotting datapath. The block sits between the button `pulse` instances and the snake datapath, and replaces the free-running slow-clock speed tap and ad-hoc signal generation.

## Interface
- `TICK_BASE`, 4000000: `CLOCK` cycles per step at level 0.
- `TICK_STEP`, 400000: cycles removed from the step period per level.
- `MIN_TICK`, 1000000: floor on the step period.
- `LEN_PER_LEVEL`, 4: snake length units per speed level.
- `MAX_LEN`, 31: length at which the game ends as a win.
- `CLOCK` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_pulse` in 1: one-cycle start/pause request.
- `left_pulse` in 1: one-cycle left-turn request.
- `right_pulse` in 1: one-cycle right-turn request.
- `collision` in 1: level from the datapath; snake hit itself or a wall.
- `len` in 5: current snake length from the datapath.
- `step` out 1: one-cycle movement strobe to the datapath.
- `turn_left` out 1: turn qualifier; high only in a `step` cycle.
- `turn_right` out 1: turn qualifier; high only in a `step` cycle.
- `game_reset` out 1: one-cycle pulse that re-initialises the datapath.
- `state` out 2: game state; 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
- `level` out 3: current speed level.
- `win` out 1: game ended by reaching `MAX_LEN`.

## Operation
- Reset values: `state`=IDLE, `level`=0, and all other outputs 0. The turn queue is empty and the tick counter is 0.
- IDLE state:
  - `start_pulse` causes `game_reset`=1 for one cycle, `win`=0, queue cleared, counter set to 0, and a transition to RUN.
- RUN state:
  - Priority order: `collision`, then `len`>=`MAX_LEN`, then `start_pulse`, then tick.
  - `collision`=1 → OVER with `win`=0.
  - `len`>=`MAX_LEN` → OVER with `win`=1.
  - `start_pulse` → PAUSE. The counter and queue are held.
  - A transition out of RUN suppresses any `step` on that edge.
- PAUSE state:
  - `start_pulse` → RUN, resuming from the held counter value.
  - Turn pulses and `collision` are ignored.
- OVER state:
  - Outputs hold.
  - `start_pulse` behaves as in IDLE: `game_reset` is pulsed and the state goes to RUN.
- Speed:
  - `level` = min(`len` / `LEN_PER_LEVEL`, 7), recomputed every cycle and registered.
  - period = max(`TICK_BASE` − `level`×`TICK_STEP`, `MIN_TICK`).
  - The counter is 32-bit. When counter >= period−1, `step` fires and the counter returns to 0; otherwise the counter increments.
  - The >= comparison makes a period that shrinks mid-count fire on the next cycle, with no wrap-around.
- Turn queue:
  - Two entries, each 1 bit (0=left, 1=right). Pushes are accepted only in RUN.
  - `left_pulse` and `right_pulse` high in the same cycle: both are dropped.
  - A push while the queue is full is dropped.
  - On a `step`, the head is popped and drives `turn_left` or `turn_right` in that same cycle. An empty queue gives no turn.
  - Push and pop in the same cycle: the pop takes the old head and the push is appended. Occupancy is unchanged when the queue was non-empty, and ends at 1 when it was empty (the pop yields no turn).
  - The queue is cleared on `game_reset` and on entry to OVER.
- Asserting `reset_n` low at any point, mid-game included, forces the reset values immediately.

## Timing
- All outputs are registered.
- `start_pulse` sampled at edge k: `game_reset` and `state`=RUN are visible after edge k, and `game_reset` drops after edge k+1.
- The first `step` occurs `period` cycles after the counter is cleared.
- `turn_*` are coincident with `step` and never asserted otherwise.
- `collision` sampled at edge k gives `state`=OVER after edge k. No `step` at edge k or later.
- A turn pulse accepted at edge k is eligible for the first `step` at edge ≥ k+1.
- `level` lags `len` by one cycle.

## Test plan
Bench parameters: `TICK_BASE`=10, `TICK_STEP`=2, `MIN_TICK`=4, `LEN_PER_LEVEL`=4, `MAX_LEN`=31.
- **Reset and start.** Hold `reset_n` low, then release it and pulse `start_pulse` with `len`=3. Required: one `game_reset` cycle, `state`=1, and `step` every 10 cycles with no turns.
- **Turn queue.** In RUN, pulse left, then right, then left before the next step. Required: the 3rd push is dropped; the next two steps carry `turn_left` then `turn_right`; the third step carries no turn.
- **Speed levels.** Set `len`=8. Required: `level`=2 and period 6. Set `len`=20. Required: `level`=5 and period 4 (the floor). Shrink the period mid-count at counter=7. Required: `step` on the next edge.
- **Collision and restart.** Assert `collision` in the same cycle the counter would fire. Required: no `step`, `state`=3, `win`=0, and the queue cleared. Then pulse `start_pulse`. Required: `game_reset` and RUN.
- **Pause and win.** Pulse `start_pulse` at counter=5. Required: `state`=2, no steps for 50 cycles, and turn pulses ignored. Resume. Required: `step` 5 cycles later. Set `len`=31. Required: `state`=3 and `win`=1.
- **Async reset mid-game.** Assert `reset_n` low mid-count with the queue holding 2 entries. Required: `state`=0, all outputs 0, and after release no `step` without a new start.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: idle/run/pause/over state machine,
// length-dependent step strobe and a 2-deep turn queue fed by button pulses.
module snake_game_ctrl #(
  parameter int unsigned TICK_BASE     = 4000000,
  parameter int unsigned TICK_STEP     = 400000,
  parameter int unsigned MIN_TICK      = 1000000,
  parameter int unsigned LEN_PER_LEVEL = 4,
  parameter int unsigned MAX_LEN       = 31
) (
  input  logic       CLOCK,
  input  logic       reset_n,
  input  logic       start_pulse,
  input  logic       left_pulse,
  input  logic       right_pulse,
  input  logic       collision,
  input  logic [4:0] len,
  output logic       step,
  output logic       turn_left,
  output logic       turn_right,
  output logic       game_reset,
  output logic [1:0] state,
  output logic [2:0] level,
  output logic       win
);

  // Inputs are single-cycle request pulses with no back-pressure: a request
  // that cannot be honoured in the cycle it arrives (queue full, wrong state)
  // is dropped, never stalled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [31:0] BASE  = 32'(TICK_BASE);
  localparam logic [31:0] DELTA = 32'(TICK_STEP);
  localparam logic [31:0] FLOOR = 32'(MIN_TICK);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  q_data_q, q_data_d;   // bit 0 is the head; 1 = right
  logic [1:0]  q_cnt_q, q_cnt_d;
  logic [2:0]  level_q, level_d;
  logic        win_q, win_d;
  logic        game_reset_d, step_d, turn_left_d, turn_right_d;
  logic        step_q, turn_left_q, turn_right_q, game_reset_q;

  logic [31:0] level_raw;
  logic [31:0] level_sub;
  logic [31:0] period;
  logic        fire;
  logic [1:0]  occ;

  always_comb begin
    level_raw = 32'(len) / LEN_PER_LEVEL;
    level_d   = (level_raw > 32'd7) ? 3'd7 : level_raw[2:0];
  end

  // Clamp before subtracting so an aggressive level never wraps the period.
  always_comb begin
    level_sub = 32'(level_q) * DELTA;
    period    = ((level_sub + FLOOR) >= BASE) ? FLOOR : (BASE - level_sub);
    fire      = (cnt_q >= (period - 32'd1));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_data_d     = q_data_q;
    q_cnt_d      = q_cnt_q;
    win_d        = win_q;
    game_reset_d = 1'b0;
    step_d       = 1'b0;
    turn_left_d  = 1'b0;
    turn_right_d = 1'b0;
    occ          = q_cnt_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_pulse) begin
          game_reset_d = 1'b1;
          win_d        = 1'b0;
          q_data_d     = 2'b00;
          q_cnt_d      = 2'd0;
          cnt_d        = 32'd0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (collision) begin
          state_d  = ST_OVER;
          win_d    = 1'b0;
          q_data_d = 2'b00;
          q_cnt_d  = 2'd0;
        end else if (32'(len) >= MAX_LEN) begin
          state_d  = ST_OVER;
          win_d    = 1'b1;
          q_data_d = 2'b00;
          q_cnt_d  = 2'd0;
        end else if (start_pulse) begin
          state_d = ST_PAUSE;
        end else begin
          if (fire) begin
            cnt_d  = 32'd0;
            step_d = 1'b1;
            if (q_cnt_q != 2'd0) begin
              turn_left_d  = ~q_data_q[0];
              turn_right_d = q_data_q[0];
              q_data_d     = {1'b0, q_data_q[1]};
              occ          = q_cnt_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
          // Append after the pop so a full queue that steps still takes the push.
          q_cnt_d = occ;
          if ((left_pulse ^ right_pulse) && (occ != 2'd2)) begin
            q_data_d[occ[0]] = right_pulse;
            q_cnt_d          = occ + 2'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (start_pulse) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      q_data_q     <= 2'b00;
      q_cnt_q      <= 2'd0;
      level_q      <= 3'd0;
      win_q        <= 1'b0;
      game_reset_q <= 1'b0;
      step_q       <= 1'b0;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_data_q     <= q_data_d;
      q_cnt_q      <= q_cnt_d;
      level_q      <= level_d;
      win_q        <= win_d;
      game_reset_q <= game_reset_d;
      step_q       <= step_d;
      turn_left_q  <= turn_left_d;
      turn_right_q <= turn_right_d;
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign win        = win_q;
  assign game_reset = game_reset_q;
  assign step       = step_q;
  assign turn_left  = turn_left_q;
  assign turn_right = turn_right_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random play, every cycle
// compared against a queue-based game model.
module tb_snake_game_ctrl;

  localparam int BASE = 10;
  localparam int DELTA = 2;
  localparam int FLOOR = 4;
  localparam int LPL = 4;
  localparam int MAXL = 31;

  logic       CLOCK;
  logic       reset_n;
  logic       start_pulse, left_pulse, right_pulse, collision;
  logic [4:0] len;
  logic       step, turn_left, turn_right, game_reset, win;
  logic [1:0] state;
  logic [2:0] level;

  snake_game_ctrl #(
    .TICK_BASE(BASE), .TICK_STEP(DELTA), .MIN_TICK(FLOOR),
    .LEN_PER_LEVEL(LPL), .MAX_LEN(MAXL)
  ) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .start_pulse(start_pulse),
    .left_pulse(left_pulse), .right_pulse(right_pulse), .collision(collision),
    .len(len), .step(step), .turn_left(turn_left), .turn_right(turn_right),
    .game_reset(game_reset), .state(state), .level(level), .win(win)
  );

  // clock / reset
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 run, 2 pause, 3 over
  int m_state, m_cnt, m_level;
  bit m_win, m_step, m_tl, m_tr, m_gr;
  logic [0:0] exp_q[$];   // pending turns, 1 = right
  logic [1:0] seen[$];    // {turn_left, turn_right} observed on each step
  int  steps_seen;
  bit  last_step;

  function automatic int period_of(input int lvl);
    int p;
    p = BASE - lvl * DELTA;
    return (p < FLOOR) ? FLOOR : p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_level = 0; m_win = 0;
    m_step = 0; m_tl = 0; m_tr = 0; m_gr = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int nl;
    logic [0:0] head;
    nl = int'(len) / LPL;
    if (nl > 7) nl = 7;
    m_step = 0; m_tl = 0; m_tr = 0; m_gr = 0;
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_state)
        0, 3: if (start_pulse) begin
          m_gr = 1; m_win = 0; exp_q.delete(); m_cnt = 0; m_state = 1;
        end
        1: begin
          if (collision) begin
            m_state = 3; m_win = 0; exp_q.delete();
          end else if (int'(len) >= MAXL) begin
            m_state = 3; m_win = 1; exp_q.delete();
          end else if (start_pulse) begin
            m_state = 2;
          end else begin
            if (m_cnt >= period_of(m_level) - 1) begin
              m_cnt = 0;
              m_step = 1;
              if (exp_q.size() > 0) begin
                head = exp_q.pop_front();
                m_tl = (head == 1'b0);
                m_tr = (head == 1'b1);
              end
            end else begin
              m_cnt = m_cnt + 1;
            end
            if ((left_pulse ^ right_pulse) && exp_q.size() < 2)
              exp_q.push_back(right_pulse);
          end
        end
        2: if (start_pulse) m_state = 1;
        default: m_state = 0;
      endcase
      m_level = nl;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("step", 32'(step), 32'(m_step));
    chk("turn_left", 32'(turn_left), 32'(m_tl));
    chk("turn_right", 32'(turn_right), 32'(m_tr));
    chk("game_reset", 32'(game_reset), 32'(m_gr));
    chk("state", 32'(state), 32'(m_state));
    chk("level", 32'(level), 32'(m_level));
    chk("win", 32'(win), 32'(m_win));
  endtask

  // driver: inputs are set just after a falling edge, pulses cleared afterwards
  task automatic tick();
    model_step();
    @(posedge CLOCK);
    #1;
    compare_all();
    last_step = step;
    if (step === 1'b1) begin
      steps_seen++;
      seen.push_back({turn_left, turn_right});
    end
    @(negedge CLOCK);
    start_pulse = 0; left_pulse = 0; right_pulse = 0; collision = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_step(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_step && n < budget);
    if (!last_step) n = -1;
  endtask

  task automatic wait_cnt(input string tag, input int target, input int budget);
    int i;
    i = 0;
    while (!(m_state == 1 && m_cnt == target) && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(m_state == 1 && m_cnt == target), 32'd1);
  endtask

  task automatic restart();
    start_pulse = 1;
    tick();
  endtask

  int n;

  initial begin
    reset_n = 0; start_pulse = 0; left_pulse = 0; right_pulse = 0;
    collision = 0; len = 5'd3;
    steps_seen = 0; last_step = 0;
    model_reset();
    @(negedge CLOCK);

    // reset and start
    ticks(3);
    reset_n = 1;
    ticks(2);
    restart();
    chk("start_game_reset", 32'(game_reset), 32'd1);
    chk("start_state", 32'(state), 32'd1);
    tick();
    chk("game_reset_drop", 32'(game_reset), 32'd0);
    steps_seen = 0;
    seen.delete();
    ticks(29);
    chk("steps_in_30", 32'(steps_seen), 32'd3);
    chk("first_steps_no_turn", 32'(seen.size() == 3 && seen[0] == 2'b00 && seen[2] == 2'b00), 32'd1);

    // turn queue: third push dropped
    run_until_step(20, n);
    left_pulse = 1; tick();
    right_pulse = 1; tick();
    left_pulse = 1; tick();
    seen.delete();
    for (int i = 0; i < 40 && seen.size() < 3; i++) tick();
    chk("turn_steps_seen", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      chk("turn_1_left", 32'(seen[0]), 32'(2'b10));
      chk("turn_2_right", 32'(seen[1]), 32'(2'b01));
      chk("turn_3_none", 32'(seen[2]), 32'(2'b00));
    end

    // speed levels
    len = 5'd8; tick();
    chk("level_len8", 32'(level), 32'd2);
    run_until_step(20, n);
    run_until_step(20, n);
    chk("period_level2", 32'(n), 32'd6);
    len = 5'd20; tick();
    chk("level_len20", 32'(level), 32'd5);
    run_until_step(20, n);
    run_until_step(20, n);
    chk("period_floor", 32'(n), 32'd4);
    len = 5'd3;
    ticks(2);
    wait_cnt("reach_cnt7", 7, 30);
    len = 5'd20;
    run_until_step(10, n);
    chk("shrink_fires_next", 32'(n), 32'd2);

    // collision on the firing cycle
    len = 5'd3;
    ticks(2);
    wait_cnt("reach_cnt8", 8, 30);
    left_pulse = 1; tick();
    collision = 1; tick();
    chk("coll_no_step", 32'(step), 32'd0);
    chk("coll_state", 32'(state), 32'd3);
    chk("coll_win", 32'(win), 32'd0);
    ticks(5);
    restart();
    chk("restart_game_reset", 32'(game_reset), 32'd1);
    chk("restart_state", 32'(state), 32'd1);
    seen.delete();
    run_until_step(15, n);
    chk("restart_period", 32'(n), 32'd10);
    chk("queue_cleared", 32'(seen.size() == 1 && seen[0] == 2'b00), 32'd1);

    // pause and win
    wait_cnt("reach_cnt5", 5, 20);
    start_pulse = 1; tick();
    chk("pause_state", 32'(state), 32'd2);
    steps_seen = 0;
    for (int i = 0; i < 50; i++) begin
      left_pulse = ($urandom_range(0, 3) == 0);
      right_pulse = ($urandom_range(0, 3) == 0);
      collision = ($urandom_range(0, 9) == 0);
      tick();
    end
    chk("pause_no_steps", 32'(steps_seen), 32'd0);
    start_pulse = 1; tick();
    chk("resume_state", 32'(state), 32'd1);
    seen.delete();
    run_until_step(15, n);
    chk("resume_step_delay", 32'(n), 32'd5);
    chk("pause_turns_ignored", 32'(seen.size() == 1 && seen[0] == 2'b00), 32'd1);
    len = 5'd31; tick();
    chk("win_state", 32'(state), 32'd3);
    chk("win_flag", 32'(win), 32'd1);
    len = 5'd3;
    ticks(3);

    // random play
    for (int i = 0; i < 600; i++) begin
      start_pulse = ($urandom_range(0, 99) < 3);
      left_pulse = ($urandom_range(0, 99) < 20);
      right_pulse = ($urandom_range(0, 99) < 20);
      collision = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 5) len = 5'($urandom_range(0, 31));
      if (m_state == 3 && $urandom_range(0, 3) == 0) start_pulse = 1;
      tick();
    end

    // async reset mid-game with two queued turns
    len = 5'd3;
    ticks(2);
    if (m_state != 1) restart();
    if (m_state == 1) begin
      run_until_step(20, n);
      left_pulse = 1; tick();
      right_pulse = 1; tick();
      ticks(2);
    end
    chk("pre_reset_queue_full", 32'(exp_q.size()), 32'd2);
    #2 reset_n = 0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_step", 32'(step), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_others", 32'({turn_left, turn_right, game_reset, win}), 32'd0);
    model_reset();
    @(negedge CLOCK);
    ticks(2);
    reset_n = 1;
    steps_seen = 0;
    ticks(30);
    chk("no_step_after_reset", 32'(steps_seen), 32'd0);
    chk("idle_after_reset", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
